// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if -- data-memory request/response bus between the
// memory-stage controller (master) and the data memory (slave).
interface mem_stage_ctrl_if;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_done;
   logic [15:0] mem_rdata;

   modport master (
      output mem_en,
      output mem_wr,
      output mem_addr,
      output mem_wdata,
      input  mem_done,
      input  mem_rdata
   );

   modport slave (
      input  mem_en,
      input  mem_wr,
      input  mem_addr,
      input  mem_wdata,
      output mem_done,
      output mem_rdata
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- M-stage controller for a variable-latency data memory.
// A load/store in XM issues a single-cycle request, the pipeline is stalled
// until the memory answers (or a 15-cycle wait expires), and the load result
// is presented to the MW pipe for one DONE cycle.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd (misaligned)
// addresses without touching memory; without it they are issued unchanged.
module mem_stage_ctrl (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    XM_memRead,
   input  logic                    XM_memWrite,
   input  logic [15:0]             XM_aluOut,
   input  logic [15:0]             XM_writeData,
   mem_stage_ctrl_if.master        mem,
   output logic [15:0]             readData,
   output logic                    stall,
   output logic                    err
);

   localparam logic [3:0] TIMEOUT_LAST = 4'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        wr_q, wr_d;
   logic        err_q, err_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        access;
   logic        ready;
   logic        misaligned;
   logic        issue;

   assign access = XM_memRead | XM_memWrite;
   assign ready  = (state_q == IDLE) || (state_q == DONE);

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = XM_aluOut[0];
`else
   assign misaligned = 1'b0;
`endif

   // The request is gated by rst_n so nothing is issued while reset is held.
   assign issue = rst_n && ready && access && !misaligned;

   // Next-state logic: request capture, response/timeout handling, fault flag
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wr_d    = wr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (access) begin
               if (misaligned) begin
                  err_d   = 1'b1;
                  rdata_d = 16'h0000;
                  state_d = DONE;
               end else begin
                  addr_d  = XM_aluOut;
                  wdata_d = XM_writeData;
                  wr_d    = XM_memWrite;
                  cnt_d   = 4'd0;
                  state_d = BUSY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (mem.mem_done) begin
               rdata_d = wr_q ? 16'h0000 : mem.mem_rdata;
               state_d = DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d   = cnt_q + 4'd1;
               err_d   = 1'b1;
               rdata_d = 16'h0000;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and request registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs: pass the XM request through in the issue cycle, hold it from registers afterwards
   always_comb begin
      mem.mem_en    = issue;
      mem.mem_wr    = issue ? XM_memWrite  : wr_q;
      mem.mem_addr  = issue ? XM_aluOut    : addr_q;
      mem.mem_wdata = issue ? XM_writeData : wdata_q;
      stall         = (ready && access) || (state_q == BUSY);
      readData      = (state_q == DONE) ? rdata_q : 16'h0000;
      err           = err_q;
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl -- directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;

   logic        clk;
   logic        rst_n;
   logic        XM_memRead;
   logic        XM_memWrite;
   logic [15:0] XM_aluOut;
   logic [15:0] XM_writeData;
   logic [15:0] readData;
   logic        stall;
   logic        err;

   int checks = 0;
   int errors = 0;

   int          sCycles;
   int          enCount;
   logic [15:0] firstAddr;
   logic        firstWr;
   logic [15:0] firstWdata;
   logic        busStable;
   logic [15:0] finalRead;
   logic        finalErr;
   logic        boundHit;

   mem_stage_ctrl_if bus();

   mem_stage_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .XM_memRead   (XM_memRead),
      .XM_memWrite  (XM_memWrite),
      .XM_aluOut    (XM_aluOut),
      .XM_writeData (XM_writeData),
      .mem          (bus),
      .readData     (readData),
      .stall        (stall),
      .err          (err)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one access in cycle 0 (XM cleared afterwards), answers at doneAt (-1 = never),
   // and records what the memory side and the pipeline side saw until stall drops.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input int doneAt, input logic [15:0] rdata);
      sCycles   = 0;
      enCount   = 0;
      busStable = 1'b1;
      boundHit  = 1'b1;
      firstAddr = 16'h0000;
      firstWr   = 1'b0;
      firstWdata = 16'h0000;
      finalRead = 16'hFFFF;
      finalErr  = 1'bx;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         XM_memRead   = (c == 0) ? rd : 1'b0;
         XM_memWrite  = (c == 0) ? wr : 1'b0;
         XM_aluOut    = (c == 0) ? addr : 16'h0000;
         XM_writeData = (c == 0) ? wdata : 16'h0000;
         bus.mem_done  = (c == doneAt);
         bus.mem_rdata = (c == doneAt) ? rdata : 16'hDEAD;
         #1;
         if (bus.mem_en) enCount++;
         if (c == 0) begin
            firstAddr  = bus.mem_addr;
            firstWr    = bus.mem_wr;
            firstWdata = bus.mem_wdata;
         end else if (stall && ((bus.mem_addr !== firstAddr) || (bus.mem_wr !== firstWr) ||
                                (bus.mem_wdata !== firstWdata))) begin
            busStable = 1'b0;
         end
         if (!stall) begin
            finalRead = readData;
            finalErr  = err;
            boundHit  = 1'b0;
            break;
         end
         sCycles++;
      end
      bus.mem_done = 1'b0;
   endtask

   // Reset state, including stall following access while reset is held
   task automatic test_reset();
      rst_n = 1'b0;
      XM_memRead = 1'b1; XM_memWrite = 1'b0; XM_aluOut = 16'h0055; XM_writeData = 16'h0000;
      bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_access: got %b expected 1", stall); end
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
      checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
      checks++; if (readData !== 16'h0000) begin errors++; $display("[TB] FAIL reset_readData: got %h expected 0000", readData); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      XM_memRead = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_idle: got %b expected 0", stall); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if ((stall !== 1'b0) || (readData !== 16'h0000)) begin errors++; $display("[TB] FAIL idle_hold: got stall=%b readData=%h expected 0/0000", stall, readData); end
   endtask

   // Load answered 3 cycles after the request
   task automatic test_load();
      applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF);
      checks++; if (sCycles != 4) begin errors++; $display("[TB] FAIL load_stall_cycles: got %0d expected 4", sCycles); end
      checks++; if (enCount != 1) begin errors++; $display("[TB] FAIL load_en_pulses: got %0d expected 1", enCount); end
      checks++; if ((firstAddr !== 16'h0040) || (firstWr !== 1'b0)) begin errors++; $display("[TB] FAIL load_request: got addr=%h wr=%b expected 0040/0", firstAddr, firstWr); end
      checks++; if (busStable !== 1'b1) begin errors++; $display("[TB] FAIL load_bus_stable: got %b expected 1", busStable); end
      checks++; if (finalRead !== 16'hBEEF) begin errors++; $display("[TB] FAIL load_readData: got %h expected beef", finalRead); end
      checks++; if (finalErr !== 1'b0) begin errors++; $display("[TB] FAIL load_err: got %b expected 0", finalErr); end
      @(negedge clk); #1;
      checks++; if (readData !== 16'h0000) begin errors++; $display("[TB] FAIL load_readData_idle: got %h expected 0000", readData); end
   endtask

   // Store answered the next cycle, and read+write together treated as a store
   task automatic test_store();
      applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234, 1, 16'hFFFF);
      checks++; if ((firstWr !== 1'b1) || (firstWdata !== 16'h1234) || (firstAddr !== 16'h0010)) begin errors++; $display("[TB] FAIL store_request: got wr=%b wdata=%h addr=%h expected 1/1234/0010", firstWr, firstWdata, firstAddr); end
      checks++; if (sCycles != 2) begin errors++; $display("[TB] FAIL store_stall_cycles: got %0d expected 2", sCycles); end
      checks++; if (finalRead !== 16'h0000) begin errors++; $display("[TB] FAIL store_readData: got %h expected 0000", finalRead); end
      checks++; if (busStable !== 1'b1) begin errors++; $display("[TB] FAIL store_bus_stable: got %b expected 1", busStable); end
      applyStimulus(1'b1, 1'b1, 16'h0020, 16'h5555, 1, 16'hFFFF);
      checks++; if ((firstWr !== 1'b1) || (finalRead !== 16'h0000)) begin errors++; $display("[TB] FAIL both_is_write: got wr=%b readData=%h expected 1/0000", firstWr, finalRead); end
   endtask

   // Second load issued in the DONE cycle of the first
   task automatic test_back_to_back();
      @(negedge clk);
      XM_memRead = 1'b1; XM_aluOut = 16'h0002;
      #1;
      checks++; if ((bus.mem_en !== 1'b1) || (bus.mem_addr !== 16'h0002)) begin errors++; $display("[TB] FAIL b2b_first_req: got en=%b addr=%h expected 1/0002", bus.mem_en, bus.mem_addr); end
      @(negedge clk);
      XM_memRead = 1'b0; XM_aluOut = 16'h0000;
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h1111;
      @(negedge clk);
      bus.mem_done = 1'b0;
      XM_memRead = 1'b1; XM_aluOut = 16'h0004;
      #1;
      checks++; if (readData !== 16'h1111) begin errors++; $display("[TB] FAIL b2b_first_data: got %h expected 1111", readData); end
      checks++; if ((bus.mem_en !== 1'b1) || (bus.mem_addr !== 16'h0004) || (stall !== 1'b1)) begin errors++; $display("[TB] FAIL b2b_second_req: got en=%b addr=%h stall=%b expected 1/0004/1", bus.mem_en, bus.mem_addr, stall); end
      @(negedge clk);
      XM_memRead = 1'b0; XM_aluOut = 16'h0000;
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h2222;
      #1;
      checks++; if ((stall !== 1'b1) || (bus.mem_en !== 1'b0)) begin errors++; $display("[TB] FAIL b2b_busy: got stall=%b en=%b expected 1/0", stall, bus.mem_en); end
      @(negedge clk);
      bus.mem_done = 1'b0;
      #1;
      checks++; if ((stall !== 1'b0) || (readData !== 16'h2222)) begin errors++; $display("[TB] FAIL b2b_second_data: got stall=%b readData=%h expected 0/2222", stall, readData); end
   endtask

   // mem_done while idle must not produce a result
   task automatic test_ignore_done();
      @(negedge clk);
      bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
      @(negedge clk);
      bus.mem_done = 1'b0;
      #1;
      checks++; if ((readData !== 16'h0000) || (stall !== 1'b0)) begin errors++; $display("[TB] FAIL ignore_done: got readData=%h stall=%b expected 0000/0", readData, stall); end
   endtask

   // mem_done in the last allowed BUSY cycle wins over timeout
   task automatic test_done_priority();
      applyStimulus(1'b1, 1'b0, 16'h0060, 16'h0000, 15, 16'h0BAD);
      checks++; if (sCycles != 16) begin errors++; $display("[TB] FAIL prio_stall_cycles: got %0d expected 16", sCycles); end
      checks++; if ((finalErr !== 1'b0) || (finalRead !== 16'h0BAD)) begin errors++; $display("[TB] FAIL prio_result: got err=%b readData=%h expected 0/0bad", finalErr, finalRead); end
   endtask

   // No response: timeout after 15 BUSY cycles, sticky err, later access still served
   task automatic test_timeout();
      applyStimulus(1'b1, 1'b0, 16'h0080, 16'h0000, -1, 16'h0000);
      checks++; if (boundHit !== 1'b0) begin errors++; $display("[TB] FAIL timeout_bound: got stall stuck expected release"); end
      checks++; if (sCycles != 16) begin errors++; $display("[TB] FAIL timeout_stall_cycles: got %0d expected 16", sCycles); end
      checks++; if ((finalErr !== 1'b1) || (finalRead !== 16'h0000)) begin errors++; $display("[TB] FAIL timeout_result: got err=%b readData=%h expected 1/0000", finalErr, finalRead); end
      applyStimulus(1'b1, 1'b0, 16'h0090, 16'h0000, 1, 16'h4321);
      checks++; if ((enCount != 1) || (sCycles != 2) || (finalRead !== 16'h4321)) begin errors++; $display("[TB] FAIL after_timeout: got en=%0d stall=%0d readData=%h expected 1/2/4321", enCount, sCycles, finalRead); end
      checks++; if (finalErr !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", finalErr); end
   endtask

   // Reset during BUSY abandons the access; a late mem_done is ignored
   task automatic test_reset_busy();
      @(negedge clk);
      XM_memWrite = 1'b1; XM_aluOut = 16'h0100; XM_writeData = 16'hCAFE;
      @(negedge clk);
      XM_memWrite = 1'b0; XM_aluOut = 16'h0000; XM_writeData = 16'h0000;
      #1;
      checks++; if ((stall !== 1'b1) || (bus.mem_wr !== 1'b1) || (bus.mem_wdata !== 16'hCAFE)) begin errors++; $display("[TB] FAIL rbusy_pre: got stall=%b wr=%b wdata=%h expected 1/1/cafe", stall, bus.mem_wr, bus.mem_wdata); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ((bus.mem_en !== 1'b0) || (bus.mem_wr !== 1'b0) || (bus.mem_addr !== 16'h0000) || (bus.mem_wdata !== 16'h0000)) begin errors++; $display("[TB] FAIL rbusy_bus: got en=%b wr=%b addr=%h wdata=%h expected all 0", bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
      checks++; if ((stall !== 1'b0) || (readData !== 16'h0000) || (err !== 1'b0)) begin errors++; $display("[TB] FAIL rbusy_pipe: got stall=%b readData=%h err=%b expected 0/0000/0", stall, readData, err); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hAAAA;
      @(negedge clk);
      bus.mem_done = 1'b0;
      #1;
      checks++; if ((stall !== 1'b0) || (readData !== 16'h0000)) begin errors++; $display("[TB] FAIL rbusy_late_done: got stall=%b readData=%h expected 0/0000", stall, readData); end
   endtask

   // Odd address: rejected when the alignment check is built in, issued otherwise
   task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
      applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0000, 1, 16'h3333);
      checks++; if ((enCount != 0) || (sCycles != 1)) begin errors++; $display("[TB] FAIL misaligned_reject: got en=%0d stall=%0d expected 0/1", enCount, sCycles); end
      checks++; if ((finalErr !== 1'b1) || (finalRead !== 16'h0000)) begin errors++; $display("[TB] FAIL misaligned_err: got err=%b readData=%h expected 1/0000", finalErr, finalRead); end
`else
      applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0000, 1, 16'h3333);
      checks++; if ((enCount != 1) || (firstAddr !== 16'h0003)) begin errors++; $display("[TB] FAIL misaligned_issue: got en=%0d addr=%h expected 1/0003", enCount, firstAddr); end
      checks++; if ((finalErr !== 1'b0) || (finalRead !== 16'h3333)) begin errors++; $display("[TB] FAIL misaligned_noerr: got err=%b readData=%h expected 0/3333", finalErr, finalRead); end
`endif
   endtask

   // Runs the scenarios in order and prints the summary
   initial begin
      test_reset();
      test_load();
      test_store();
      test_back_to_back();
      test_ignore_done();
      test_done_priority();
      test_timeout();
      test_reset_busy();
      test_misaligned();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guards against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: XM_memRead  in  1  load in M stage; XM_memWrite  in  1  store in M stage.
REQ-004 SHALL have ports: XM_aluOut  in  16  effective address; XM_writeData  in  16  store data.
REQ-005 SHALL have ports: mem_en  out  1  request pulse; mem_wr  out  1  1=write; mem_addr  out  16; mem_wdata  out  16.
REQ-006 SHALL have ports: mem_done  in  1  access complete; mem_rdata  in  16  read data, valid with mem_done.
REQ-007 SHALL have ports: readData  out  16  load result to MW pipe; stall  out  1  freeze PC/FD/DX/XM, bubble MW; err  out  1  sticky fault.
REQ-008 SHALL have no parameters; timeout limit fixed at 15 cycles.

Function
REQ-009 SHALL define access = XM_memRead | XM_memWrite; both asserted is treated as write.
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 SHALL, in IDLE or DONE with access=1, assert mem_en for exactly one cycle, mem_wr=XM_memWrite, mem_addr=XM_aluOut, mem_wdata=XM_writeData, and go to BUSY.
REQ-012 SHALL hold mem_addr, mem_wdata, mem_wr registered and stable throughout BUSY; mem_en=0 in BUSY.
REQ-013 SHALL assert stall combinationally when (IDLE or DONE) and access=1, and for every BUSY cycle; stall=0 otherwise.
REQ-014 SHALL sample mem_done only in BUSY; mem_done outside BUSY is ignored.
REQ-015 SHALL, on mem_done in BUSY, capture mem_rdata (reads) or 0 (writes) into rdata_q and go to DONE.
REQ-016 SHALL drive readData=rdata_q in DONE and 16'h0000 in all other states.
REQ-017 SHALL, with no access, move DONE to IDLE next cycle; IDLE with no access stays IDLE.
REQ-018 SHALL give minimum access latency of 2 stall cycles (request cycle + one BUSY cycle) before DONE.
REQ-019 SHALL run a 4-bit wait counter, cleared on entering BUSY, incremented each BUSY cycle without mem_done.
REQ-020 SHALL, when the counter reaches 15 without mem_done, set err=1, load rdata_q=0, go to DONE.
REQ-021 SHALL give mem_done priority over timeout in the same cycle (no err).
REQ-022 SHALL hold err at 1 until reset; err does not block later accesses.

Reset
REQ-023 SHALL on rst_n=0 immediately force IDLE, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata_q=0, counter=0, err=0, readData=0.
REQ-024 SHALL abandon an in-flight access on reset mid-BUSY; no response after reset release.
REQ-025 SHALL evaluate stall from inputs after reset, so stall=1 during reset only if access=1 (FSM in IDLE).

Configuration
REQ-026 SHALL, with MEM_ALIGN_CHECK_EN defined, treat access with XM_aluOut[0]=1 as misaligned: no mem_en, set err=1, go directly to DONE with rdata_q=0 (one stall cycle).
REQ-027 SHALL, without MEM_ALIGN_CHECK_EN, issue misaligned addresses to memory unchanged with no error.

Verification
REQ-028 Load addr 16'h0040, mem_done 3 cycles after mem_en with rdata 16'hBEEF -> mem_en 1 cycle, stall 4 cycles, DONE readData=16'hBEEF, err=0.
REQ-029 Store addr 16'h0010 data 16'h1234, mem_done next cycle -> mem_wr=1, mem_wdata=16'h1234, stall 2 cycles, readData=0.
REQ-030 Load with mem_done never asserted -> stall 16 cycles, err=1, readData=0 in DONE, next access still issued.
REQ-031 Back-to-back loads 16'h0002 then 16'h0004 -> second mem_en in the DONE cycle of the first, addr 16'h0004.
REQ-032 rst_n low during BUSY -> all outputs 0 immediately, late mem_done ignored, err=0.
REQ-033 MEM_ALIGN_CHECK_EN defined, load 16'h0003 -> no mem_en, stall 1 cycle, err=1; undefined -> mem_en with mem_addr=16'h0003.
